// File: rtl/vera_video_pkg.sv
// Shared video-path constants and types for the palette lookup stage.
// Holds palette geometry, RGB field positions and pipeline latency figures.
package vera_video_pkg;

    localparam int PAL_IDX_W   = 8;
    localparam int PAL_ENTRY_W = 16;
    localparam int CPU_ADDR_W  = 9;
    localparam int BYTE_W      = 8;
    localparam int CH_W        = 4;

    localparam int R_LSB = 8;
    localparam int G_LSB = 4;
    localparam int B_LSB = 0;

    // Index-in to RGB-out latency without and with the optional output register.
    localparam int LAT_BASE    = 2;
    localparam int LAT_OUT_REG = 3;

    typedef struct packed {
        logic [CH_W-1:0] r;
        logic [CH_W-1:0] g;
        logic [CH_W-1:0] b;
    } rgb_t;

    typedef struct packed {
        logic blank;
        logic hsync;
        logic vsync;
    } sync_t;

    localparam sync_t SYNC_RST = '{blank: 1'b1, hsync: 1'b0, vsync: 1'b0};

endpackage

// File: rtl/palette_cpu_wr.sv
// CPU byte write to palette_ram word write: one registered write cycle per strobe,
// byte lane chosen by the address LSB and the byte replicated onto both lanes.
module palette_cpu_wr
    import vera_video_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   wr,
    input  logic [CPU_ADDR_W-1:0]  addr,
    input  logic [BYTE_W-1:0]      data,
    output logic                   wr_en,
    output logic [1:0]             ben,
    output logic [PAL_IDX_W-1:0]   wr_addr,
    output logic [PAL_ENTRY_W-1:0] wr_data
);

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_en   <= 1'b0;
            ben     <= 2'b00;
            wr_addr <= '0;
            wr_data <= '0;
        end else begin
            wr_en <= wr;
            if (wr) begin
                ben     <= addr[0] ? 2'b10 : 2'b01;
                wr_addr <= addr[CPU_ADDR_W-1:1];
                wr_data <= {data, data};
            end
        end
    end

endmodule

// File: rtl/palette_lookup.sv
// Palette lookup pixel stage: index stream -> palette_ram read -> 4:4:4 RGB with aligned sync/blank.
// Define PALETTE_LOOKUP_CHROMA_KILL_EN to add chroma_kill_i (greyscale luma on all channels).
module palette_lookup
    import vera_video_pkg::*;
#(
    parameter int OUT_REG   = 1,
    parameter int BORDER_EN = 1
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   pix_valid_i,
    input  logic [PAL_IDX_W-1:0]   pix_idx_i,
    input  logic                   border_i,
    input  logic [PAL_IDX_W-1:0]   border_idx_i,
    input  logic                   blank_i,
    input  logic                   hsync_i,
    input  logic                   vsync_i,
`ifdef PALETTE_LOOKUP_CHROMA_KILL_EN
    input  logic                   chroma_kill_i,
`endif
    input  logic                   cpu_wr_i,
    input  logic [CPU_ADDR_W-1:0]  cpu_addr_i,
    input  logic [BYTE_W-1:0]      cpu_data_i,
    output logic [PAL_IDX_W-1:0]   pal_rd_addr_o,
    input  logic [PAL_ENTRY_W-1:0] pal_rd_data_i,
    output logic                   pal_wr_en_o,
    output logic [1:0]             pal_ben_o,
    output logic [PAL_IDX_W-1:0]   pal_wr_addr_o,
    output logic [PAL_ENTRY_W-1:0] pal_wr_data_o,
    output logic [CH_W-1:0]        red_o,
    output logic [CH_W-1:0]        green_o,
    output logic [CH_W-1:0]        blue_o,
    output logic                   hsync_o,
    output logic                   vsync_o,
    output logic                   blank_o
);

    logic                           border_act;
    sync_t                          sb_p1;
    sync_t                          sb_p2;
    rgb_t                           rgb_d2;
    rgb_t                           rgb_p2;
    logic [PAL_ENTRY_W-1:3*CH_W]    unused_hi;

    assign unused_hi     = pal_rd_data_i[PAL_ENTRY_W-1:3*CH_W];
    assign border_act    = (BORDER_EN != 0) && border_i;
    assign pal_rd_addr_o = border_act ? border_idx_i : (pix_valid_i ? pix_idx_i : '0);

`ifdef PALETTE_LOOKUP_CHROMA_KILL_EN
    logic kill_p1;

    // Y = (5R + 9G + 2B) >> 4; the weighted sum peaks at 240 so 8 bits never overflow.
    function automatic rgb_t luma(input rgb_t c);
        logic [7:0]      sum;
        logic [CH_W-1:0] y;
        sum = 8'd5 * {4'd0, c.r} + 8'd9 * {4'd0, c.g} + 8'd2 * {4'd0, c.b};
        y   = CH_W'(sum >> CH_W);
        return '{r: y, g: y, b: y};
    endfunction

    always_ff @(posedge clk_i) begin
        kill_p1 <= chroma_kill_i;
    end
`endif

    // Stage 1: sideband registered alongside the palette RAM read.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sb_p1 <= SYNC_RST;
        end else begin
            sb_p1 <= '{blank: blank_i | ~(pix_valid_i | border_act),
                       hsync: hsync_i,
                       vsync: vsync_i};
        end
    end

    always_comb begin
        rgb_d2 = '0;
        if (!sb_p1.blank) begin
            rgb_d2 = '{r: pal_rd_data_i[R_LSB +: CH_W],
                       g: pal_rd_data_i[G_LSB +: CH_W],
                       b: pal_rd_data_i[B_LSB +: CH_W]};
        end
`ifdef PALETTE_LOOKUP_CHROMA_KILL_EN
        if (OUT_REG == 0 && kill_p1) begin
            rgb_d2 = luma(rgb_d2);
        end
`endif
    end

    // Stage 2: RGB from the RAM data, blank forcing black.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rgb_p2 <= '0;
            sb_p2  <= SYNC_RST;
        end else begin
            rgb_p2 <= rgb_d2;
            sb_p2  <= sb_p1;
        end
    end

    generate
        if (OUT_REG != 0) begin : g_out_reg
            rgb_t  rgb_d3;
            rgb_t  rgb_p3;
            sync_t sb_p3;

`ifdef PALETTE_LOOKUP_CHROMA_KILL_EN
            logic kill_p2;

            always_ff @(posedge clk_i) begin
                kill_p2 <= kill_p1;
            end

            always_comb begin
                rgb_d3 = rgb_p2;
                if (kill_p2) begin
                    rgb_d3 = luma(rgb_p2);
                end
            end
`else
            always_comb begin
                rgb_d3 = rgb_p2;
            end
`endif

            // Stage 3: optional output register, luma folded in here.
            always_ff @(posedge clk_i) begin
                if (rst_i) begin
                    rgb_p3 <= '0;
                    sb_p3  <= SYNC_RST;
                end else begin
                    rgb_p3 <= rgb_d3;
                    sb_p3  <= sb_p2;
                end
            end

            assign red_o   = rgb_p3.r;
            assign green_o = rgb_p3.g;
            assign blue_o  = rgb_p3.b;
            assign hsync_o = sb_p3.hsync;
            assign vsync_o = sb_p3.vsync;
            assign blank_o = sb_p3.blank;
        end else begin : g_no_out_reg
            assign red_o   = rgb_p2.r;
            assign green_o = rgb_p2.g;
            assign blue_o  = rgb_p2.b;
            assign hsync_o = sb_p2.hsync;
            assign vsync_o = sb_p2.vsync;
            assign blank_o = sb_p2.blank;
        end
    endgenerate

    palette_cpu_wr u_cpu_wr (
        .clk     (clk_i),
        .rst     (rst_i),
        .wr      (cpu_wr_i),
        .addr    (cpu_addr_i),
        .data    (cpu_data_i),
        .wr_en   (pal_wr_en_o),
        .ben     (pal_ben_o),
        .wr_addr (pal_wr_addr_o),
        .wr_data (pal_wr_data_o)
    );

endmodule

// File: tb/tb_palette_lookup.sv
// Bench for palette_lookup: two instances (OUT_REG=1 and OUT_REG=0) share one stimulus stream,
// each with its own palette_ram model, checked against a cycle-indexed reference model.
`timescale 1ns/1ps
module tb_palette_lookup;

    localparam int          MAXC  = 4096;
    localparam logic [14:0] RST_V = 15'h4000;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst, pix_valid, border, blank, hsync, vsync, cpu_wr, kill;
    logic [7:0] pix_idx, border_idx, cpu_data;
    logic [8:0] cpu_addr;

    logic [7:0]  rd_addr3, waddr3, rd_addr2, waddr2;
    logic        wen3, wen2;
    logic [1:0]  ben3, ben2;
    logic [15:0] wdata3, rdata3, wdata2, rdata2;
    logic [3:0]  r3, g3, b3, r2, g2, b2;
    logic        hs3, vs3, bl3, hs2, vs2, bl2;
    logic [14:0] got3, got2;

    assign got3 = {bl3, hs3, vs3, r3, g3, b3};
    assign got2 = {bl2, hs2, vs2, r2, g2, b2};

    palette_lookup #(.OUT_REG(1), .BORDER_EN(1)) dut3 (
        .clk_i(clk), .rst_i(rst), .pix_valid_i(pix_valid), .pix_idx_i(pix_idx),
        .border_i(border), .border_idx_i(border_idx), .blank_i(blank),
        .hsync_i(hsync), .vsync_i(vsync),
`ifdef PALETTE_LOOKUP_CHROMA_KILL_EN
        .chroma_kill_i(kill),
`endif
        .cpu_wr_i(cpu_wr), .cpu_addr_i(cpu_addr), .cpu_data_i(cpu_data),
        .pal_rd_addr_o(rd_addr3), .pal_rd_data_i(rdata3), .pal_wr_en_o(wen3),
        .pal_ben_o(ben3), .pal_wr_addr_o(waddr3), .pal_wr_data_o(wdata3),
        .red_o(r3), .green_o(g3), .blue_o(b3), .hsync_o(hs3), .vsync_o(vs3), .blank_o(bl3)
    );

    palette_lookup #(.OUT_REG(0), .BORDER_EN(1)) dut2 (
        .clk_i(clk), .rst_i(rst), .pix_valid_i(pix_valid), .pix_idx_i(pix_idx),
        .border_i(border), .border_idx_i(border_idx), .blank_i(blank),
        .hsync_i(hsync), .vsync_i(vsync),
`ifdef PALETTE_LOOKUP_CHROMA_KILL_EN
        .chroma_kill_i(kill),
`endif
        .cpu_wr_i(cpu_wr), .cpu_addr_i(cpu_addr), .cpu_data_i(cpu_data),
        .pal_rd_addr_o(rd_addr2), .pal_rd_data_i(rdata2), .pal_wr_en_o(wen2),
        .pal_ben_o(ben2), .pal_wr_addr_o(waddr2), .pal_wr_data_o(wdata2),
        .red_o(r2), .green_o(g2), .blue_o(b2), .hsync_o(hs2), .vsync_o(vs2), .blank_o(bl2)
    );

    // palette_ram models: 1-cycle registered read, byte-enabled write, old data on collision
    logic [15:0] mem3 [256];
    logic [15:0] mem2 [256];

    always @(posedge clk) begin
        rdata3 <= mem3[rd_addr3];
        if (wen3) begin
            if (ben3[0]) mem3[waddr3][7:0]  <= wdata3[7:0];
            if (ben3[1]) mem3[waddr3][15:8] <= wdata3[15:8];
        end
    end

    always @(posedge clk) begin
        rdata2 <= mem2[rd_addr2];
        if (wen2) begin
            if (ben2[0]) mem2[waddr2][7:0]  <= wdata2[7:0];
            if (ben2[1]) mem2[waddr2][15:8] <= wdata2[15:8];
        end
    end

    // reference model state
    logic [15:0] pal [256];
    logic [14:0] exp3 [MAXC];
    logic [14:0] exp2 [MAXC];
    logic        exp_wen [MAXC];
    logic [25:0] exp_wvec [MAXC];
    logic        pend_v [MAXC];
    logic [8:0]  pend_a [MAXC];
    logic [7:0]  pend_d [MAXC];
    int          cyc;
    int          n_checks;
    int          n_fail;

    task automatic idle_inputs();
        rst = 1'b0; pix_valid = 1'b0; pix_idx = 8'h00; border = 1'b0; border_idx = 8'h00;
        blank = 1'b1; hsync = 1'b0; vsync = 1'b0; cpu_wr = 1'b0; cpu_addr = 9'h000;
        cpu_data = 8'h00; kill = 1'b0;
    endtask

    // Records what the current inputs should produce, then advances one clock.
    task automatic step();
        logic [7:0]  a;
        logic [15:0] e;
        logic [14:0] px;
        logic        bl;
        int          r, g, b, y;
        if (cyc >= 2 && pend_v[cyc-2]) begin
            if (pend_a[cyc-2][0]) pal[pend_a[cyc-2][8:1]][15:8] = pend_d[cyc-2];
            else                  pal[pend_a[cyc-2][8:1]][7:0]  = pend_d[cyc-2];
        end
        bl = blank | ~(pix_valid | border);
        if (border)         a = border_idx;
        else if (pix_valid) a = pix_idx;
        else                a = 8'h00;
        e = pal[a];
        r = (int'(e) / 256) % 16;
        g = (int'(e) / 16) % 16;
        b = int'(e) % 16;
        if (kill) begin
            y = (5 * r + 9 * g + 2 * b) / 16;
            r = y; g = y; b = y;
        end
        if (bl) px = {1'b1, hsync, vsync, 12'h000};
        else    px = {1'b0, hsync, vsync, 4'(r), 4'(g), 4'(b)};
        exp3[cyc+3] = px;
        exp2[cyc+2] = px;
        exp_wen[cyc+1]  = cpu_wr & ~rst;
        exp_wvec[cyc+1] = {cpu_addr[8:1], 2'(1 << cpu_addr[0]), cpu_data, cpu_data};
        pend_v[cyc] = cpu_wr & ~rst;
        pend_a[cyc] = cpu_addr;
        pend_d[cyc] = cpu_data;
        if (rst) begin
            for (int k = 1; k <= 3; k++) exp3[cyc+k] = RST_V;
            for (int k = 1; k <= 2; k++) exp2[cyc+k] = RST_V;
        end
        @(posedge clk);
        @(negedge clk);
        cyc++;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step();
            n_checks++;
            if (got3 !== RST_V) begin n_fail++; $display("FAIL reset_video3 got=%h exp=%h", got3, RST_V); end
            n_checks++;
            if (got2 !== RST_V) begin n_fail++; $display("FAIL reset_video2 got=%h exp=%h", got2, RST_V); end
            n_checks++;
            if ({wen3, ben3, waddr3, wdata3} !== 27'h0) begin
                n_fail++; $display("FAIL reset_wr got=%h exp=0", {wen3, ben3, waddr3, wdata3});
            end
        end
        rst = 1'b0;
        step();
    endtask

    task automatic test_cpu_fill();
        idle_inputs();
        for (int a = 0; a < 512; a++) begin
            cpu_wr   = 1'b1;
            cpu_addr = 9'(a);
            if (a == 'h00A)      cpu_data = 8'h80;
            else if (a == 'h00B) cpu_data = 8'h0F;
            else                 cpu_data = 8'($urandom);
            step();
            n_checks++;
            if (wen3 !== exp_wen[cyc]) begin
                n_fail++; $display("FAIL fill_wen got=%b exp=%b", wen3, exp_wen[cyc]);
            end
            n_checks++;
            if ({waddr3, ben3, wdata3} !== exp_wvec[cyc]) begin
                n_fail++; $display("FAIL fill_wvec got=%h exp=%h", {waddr3, ben3, wdata3}, exp_wvec[cyc]);
            end
        end
        idle_inputs();
        step();
        n_checks++;
        if (wen3 !== 1'b0) begin n_fail++; $display("FAIL fill_wen_end got=%b exp=0", wen3); end
        step();
    endtask

    task automatic test_cpu_single();
        idle_inputs();
        cpu_wr = 1'b1; cpu_addr = 9'h0FF; cpu_data = 8'hAB;
        step();
        cpu_wr = 1'b0;
        n_checks++;
        if ({wen3, waddr3, ben3, wdata3} !== {1'b1, 8'h7F, 2'b10, 16'hABAB}) begin
            n_fail++; $display("FAIL single_write got=%h exp=%h", {wen3, waddr3, ben3, wdata3},
                               {1'b1, 8'h7F, 2'b10, 16'hABAB});
        end
        step();
        n_checks++;
        if (wen3 !== 1'b0) begin n_fail++; $display("FAIL single_wen_width got=%b exp=0", wen3); end
        step();
    endtask

    task automatic test_entry5();
        idle_inputs();
        pix_valid = 1'b1; pix_idx = 8'h05; blank = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            step();
            n_checks++;
            if (got3 !== exp3[cyc]) begin n_fail++; $display("FAIL entry5_video3 got=%h exp=%h", got3, exp3[cyc]); end
            n_checks++;
            if (got2 !== exp2[cyc]) begin n_fail++; $display("FAIL entry5_video2 got=%h exp=%h", got2, exp2[cyc]); end
            if (k == 1) begin
                n_checks++;
                if (bl2 !== 1'b1) begin n_fail++; $display("FAIL entry5_early2 got=%b exp=1", bl2); end
            end
            if (k == 2) begin
                n_checks++;
                if ({bl2, r2, g2, b2} !== 13'h0F80) begin
                    n_fail++; $display("FAIL entry5_rgb2 got=%h exp=0f80", {bl2, r2, g2, b2});
                end
                n_checks++;
                if (bl3 !== 1'b1) begin n_fail++; $display("FAIL entry5_early3 got=%b exp=1", bl3); end
            end
            if (k == 3) begin
                n_checks++;
                if ({bl3, r3, g3, b3} !== 13'h0F80) begin
                    n_fail++; $display("FAIL entry5_rgb3 got=%h exp=0f80", {bl3, r3, g3, b3});
                end
            end
        end
        idle_inputs();
        step();
    endtask

    task automatic test_blank();
        idle_inputs();
        pix_valid = 1'b1; pix_idx = 8'h05; blank = 1'b1; hsync = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            step();
            n_checks++;
            if (got3 !== exp3[cyc]) begin n_fail++; $display("FAIL blank_video3 got=%h exp=%h", got3, exp3[cyc]); end
            n_checks++;
            if (got2 !== exp2[cyc]) begin n_fail++; $display("FAIL blank_video2 got=%h exp=%h", got2, exp2[cyc]); end
        end
        n_checks++;
        if (got3 !== {1'b1, 1'b1, 1'b0, 12'h000}) begin
            n_fail++; $display("FAIL blank_hsync_align got=%h exp=6000", got3);
        end
        idle_inputs();
        for (int k = 0; k < 3; k++) step();
    endtask

    task automatic test_border();
        idle_inputs();
        border = 1'b1; border_idx = 8'h05; pix_valid = 1'b0; pix_idx = 8'($urandom); blank = 1'b0;
        #1;
        n_checks++;
        if (rd_addr3 !== 8'h05 || rd_addr2 !== 8'h05) begin
            n_fail++; $display("FAIL border_rd_addr got=%h/%h exp=05", rd_addr3, rd_addr2);
        end
        for (int k = 1; k <= 3; k++) begin
            step();
            n_checks++;
            if (got3 !== exp3[cyc]) begin n_fail++; $display("FAIL border_video3 got=%h exp=%h", got3, exp3[cyc]); end
            n_checks++;
            if (got2 !== exp2[cyc]) begin n_fail++; $display("FAIL border_video2 got=%h exp=%h", got2, exp2[cyc]); end
        end
        n_checks++;
        if (got3 !== 15'h0F80) begin n_fail++; $display("FAIL border_colour got=%h exp=0f80", got3); end
        idle_inputs();
        for (int k = 0; k < 3; k++) step();
    endtask

    task automatic test_hsync_width();
        int start, rise3, rise2, w3, w2;
        logic p3, p2;
        idle_inputs();
        start = -1; rise3 = -1; rise2 = -1; w3 = 0; w2 = 0; p3 = 1'b0; p2 = 1'b0;
        for (int k = 0; k < 112; k++) begin
            pix_valid = 1'($urandom_range(0, 1));
            pix_idx   = 8'($urandom);
            blank     = 1'($urandom_range(0, 3) == 0);
            hsync     = (k >= 5 && k < 101);
            if (k == 5) start = cyc;
            step();
            n_checks++;
            if (got3 !== exp3[cyc]) begin n_fail++; $display("FAIL hsync_video3 got=%h exp=%h", got3, exp3[cyc]); end
            n_checks++;
            if (got2 !== exp2[cyc]) begin n_fail++; $display("FAIL hsync_video2 got=%h exp=%h", got2, exp2[cyc]); end
            if (hs3 && !p3) rise3 = cyc;
            if (hs2 && !p2) rise2 = cyc;
            if (hs3 === 1'b1) w3++;
            if (hs2 === 1'b1) w2++;
            p3 = hs3; p2 = hs2;
        end
        n_checks++;
        if (rise3 !== start + 3 || w3 != 96) begin
            n_fail++; $display("FAIL hsync_shift3 got=%0d/%0d exp=%0d/96", rise3 - start, w3, 3);
        end
        n_checks++;
        if (rise2 !== start + 2 || w2 != 96) begin
            n_fail++; $display("FAIL hsync_shift2 got=%0d/%0d exp=%0d/96", rise2 - start, w2, 2);
        end
        idle_inputs();
        step();
    endtask

    task automatic test_random();
        logic [7:0] ea;
        idle_inputs();
        for (int k = 0; k < 400; k++) begin
            pix_valid  = 1'($urandom_range(0, 3) != 0);
            pix_idx    = 8'($urandom_range(0, 15));
            border     = 1'($urandom_range(0, 7) == 0);
            border_idx = 8'($urandom_range(0, 15));
            blank      = 1'($urandom_range(0, 7) == 0);
            hsync      = 1'($urandom_range(0, 1));
            vsync      = 1'($urandom_range(0, 1));
            cpu_wr     = 1'($urandom_range(0, 2) == 0);
            cpu_addr   = 9'($urandom_range(0, 31));
            cpu_data   = 8'($urandom);
`ifdef PALETTE_LOOKUP_CHROMA_KILL_EN
            kill       = 1'($urandom_range(0, 1));
`endif
            ea = border ? border_idx : (pix_valid ? pix_idx : 8'h00);
            #1;
            n_checks++;
            if (rd_addr3 !== ea) begin n_fail++; $display("FAIL rand_rd_addr got=%h exp=%h", rd_addr3, ea); end
            step();
            n_checks++;
            if (got3 !== exp3[cyc]) begin n_fail++; $display("FAIL rand_video3 got=%h exp=%h", got3, exp3[cyc]); end
            n_checks++;
            if (got2 !== exp2[cyc]) begin n_fail++; $display("FAIL rand_video2 got=%h exp=%h", got2, exp2[cyc]); end
            n_checks++;
            if (wen3 !== exp_wen[cyc] || (exp_wen[cyc] && {waddr3, ben3, wdata3} !== exp_wvec[cyc])) begin
                n_fail++; $display("FAIL rand_write got=%b/%h exp=%b/%h", wen3, {waddr3, ben3, wdata3},
                                   exp_wen[cyc], exp_wvec[cyc]);
            end
        end
        idle_inputs();
        for (int k = 0; k < 3; k++) step();
    endtask

    task automatic test_reset_mid();
        idle_inputs();
        cpu_wr = 1'b1; cpu_addr = 9'h00A; cpu_data = 8'h80;
        step();
        cpu_addr = 9'h00B; cpu_data = 8'h0F;
        step();
        idle_inputs();
        pix_valid = 1'b1; pix_idx = 8'h05; blank = 1'b0;
        for (int k = 0; k < 5; k++) step();
        rst = 1'b1; cpu_wr = 1'b1; cpu_addr = 9'h00A; cpu_data = 8'h00;
        step();
        rst = 1'b0; cpu_wr = 1'b0;
        n_checks++;
        if (got3 !== RST_V) begin n_fail++; $display("FAIL midrst_video3 got=%h exp=%h", got3, RST_V); end
        n_checks++;
        if (got2 !== RST_V) begin n_fail++; $display("FAIL midrst_video2 got=%h exp=%h", got2, RST_V); end
        n_checks++;
        if (wen3 !== 1'b0) begin n_fail++; $display("FAIL midrst_wen got=%b exp=0", wen3); end
        for (int k = 0; k < 5; k++) begin
            step();
            n_checks++;
            if (got3 !== exp3[cyc]) begin n_fail++; $display("FAIL midrst_after3 got=%h exp=%h", got3, exp3[cyc]); end
            n_checks++;
            if (got2 !== exp2[cyc]) begin n_fail++; $display("FAIL midrst_after2 got=%h exp=%h", got2, exp2[cyc]); end
        end
        n_checks++;
        if (got3 !== 15'h0F80) begin n_fail++; $display("FAIL midrst_dropped_write got=%h exp=0f80", got3); end
        idle_inputs();
        for (int k = 0; k < 3; k++) step();
    endtask

`ifdef PALETTE_LOOKUP_CHROMA_KILL_EN
    task automatic test_chroma_kill();
        logic [7:0] bytes [4];
        logic [11:0] want;
        bytes[0] = 8'hFF; bytes[1] = 8'h0F; bytes[2] = 8'h00; bytes[3] = 8'h0F;
        idle_inputs();
        for (int a = 0; a < 4; a++) begin
            cpu_wr = 1'b1; cpu_addr = 9'(32 + a); cpu_data = bytes[a];
            step();
        end
        idle_inputs();
        for (int k = 0; k < 2; k++) step();
        for (int e = 0; e < 2; e++) begin
            pix_valid = 1'b1; blank = 1'b0; kill = 1'b1; pix_idx = 8'(16 + e);
            want = (e == 0) ? 12'hFFF : 12'h444;
            for (int k = 1; k <= 3; k++) begin
                step();
                n_checks++;
                if (got3 !== exp3[cyc]) begin n_fail++; $display("FAIL kill_video3 got=%h exp=%h", got3, exp3[cyc]); end
                n_checks++;
                if (got2 !== exp2[cyc]) begin n_fail++; $display("FAIL kill_video2 got=%h exp=%h", got2, exp2[cyc]); end
                if (k == 2) begin
                    n_checks++;
                    if ({r2, g2, b2} !== want) begin n_fail++; $display("FAIL kill_rgb2 got=%h exp=%h", {r2, g2, b2}, want); end
                end
                if (k == 3) begin
                    n_checks++;
                    if ({r3, g3, b3} !== want) begin n_fail++; $display("FAIL kill_rgb3 got=%h exp=%h", {r3, g3, b3}, want); end
                end
            end
        end
        idle_inputs();
        for (int k = 0; k < 3; k++) step();
    endtask
`endif

    initial begin
        n_checks = 0;
        n_fail   = 0;
        cyc      = 0;
        for (int i = 0; i < 256; i++) pal[i] = 16'h0000;
        for (int i = 0; i < MAXC; i++) begin
            exp3[i] = RST_V; exp2[i] = RST_V; exp_wen[i] = 1'b0; exp_wvec[i] = '0; pend_v[i] = 1'b0;
        end
        idle_inputs();
        @(negedge clk);
        test_reset();
        test_cpu_fill();
        test_cpu_single();
        test_entry5();
        test_blank();
        test_border();
        test_hsync_width();
        test_random();
        test_reset_mid();
`ifdef PALETTE_LOOKUP_CHROMA_KILL_EN
        test_chroma_kill();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
